// File: rtl/uart_2_mem_resp.sv
// UART-to-memory bridge: receives a command frame over 8N1 serial, issues one
// bus transaction, and answers with the read data (4 bytes) or a 0xA5 ack.
module uart_2_mem_resp #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [12:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_BUS_REQ, S_BUS_WAIT, S_RESP
    } state_t;

    // receive path
    logic [1:0]    rx_sync_reg;
    logic          rx_prev_reg;
    logic          rx_on_reg;
    logic [3:0]    rx_bit_reg;     // 0 = start bit, 1..8 = data, 9 = stop
    logic [CW-1:0] rx_cnt_reg;
    logic [7:0]    rx_shift_reg;
    logic          rx_valid_reg;   // one-cycle strobe: good byte in rx_shift_reg
    logic          rx_err_reg;     // one-cycle strobe: stop bit was low
    logic          rx_s;

    // command / response path
    state_t        state_reg, state_next;
    logic          we_reg, we_next;
    logic [12:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [1:0]    wcnt_reg, wcnt_next;
    logic [31:0]   resp_reg, resp_next;
    logic [1:0]    last_reg, last_next;       // index of final response byte
    logic [1:0]    tx_idx_reg, tx_idx_next;
    logic [3:0]    tx_bit_reg, tx_bit_next;   // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic          resp_take;
    logic [7:0]    tx_byte;
    logic [9:0]    tx_frame;

    assign rx_s = rx_sync_reg[1];

    // Synchronise rx, detect the start edge, and shift in one 8N1 byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_on_reg    <= 1'b0;
            rx_bit_reg   <= 4'd0;
            rx_cnt_reg   <= '0;
            rx_shift_reg <= 8'h00;
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], rx_i};
            rx_prev_reg  <= rx_s;
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
            if (!rx_on_reg) begin
                rx_cnt_reg <= '0;
                rx_bit_reg <= 4'd0;
                if (rx_prev_reg && !rx_s) rx_on_reg <= 1'b1;
            end else if (rx_bit_reg == 4'd0) begin
                // mid start bit: a high line here means it was only a glitch
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_reg <= '0;
                    if (rx_s) rx_on_reg  <= 1'b0;
                    else      rx_bit_reg <= 4'd1;
                end else begin
                    rx_cnt_reg <= rx_cnt_reg + CW'(1);
                end
            end else if (rx_cnt_reg == BIT_LAST) begin
                rx_cnt_reg <= '0;
                if (rx_bit_reg == 4'd9) begin
                    rx_on_reg  <= 1'b0;
                    rx_bit_reg <= 4'd0;
                    if (rx_s) rx_valid_reg <= 1'b1;
                    else      rx_err_reg   <= 1'b1;
                end else begin
                    rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                    rx_bit_reg   <= rx_bit_reg + 4'd1;
                end
            end else begin
                rx_cnt_reg <= rx_cnt_reg + CW'(1);
            end
        end
    end

    // Command FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= S_IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= 13'h0000;
            wdata_reg  <= 32'h0000_0000;
            wcnt_reg   <= 2'd0;
            resp_reg   <= 32'h0000_0000;
            last_reg   <= 2'd0;
            tx_idx_reg <= 2'd0;
            tx_bit_reg <= 4'd0;
            tx_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            wcnt_reg   <= wcnt_next;
            resp_reg   <= resp_next;
            last_reg   <= last_next;
            tx_idx_reg <= tx_idx_next;
            tx_bit_reg <= tx_bit_next;
            tx_cnt_reg <= tx_cnt_next;
        end
    end

    // Command FSM next state: frame decode, bus handshake, response serialiser.
    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        wcnt_next   = wcnt_reg;
        resp_next   = resp_reg;
        last_next   = last_reg;
        tx_idx_next = tx_idx_reg;
        tx_bit_next = tx_bit_reg;
        tx_cnt_next = tx_cnt_reg;
        // a response arriving together with the grant counts as the response
        resp_take = ((state_reg == S_BUS_REQ) && mem_gnt_i && mem_rvalid_i) ||
                    ((state_reg == S_BUS_WAIT) && mem_rvalid_i);
        case (state_reg)
            S_IDLE: begin
                wcnt_next = 2'd0;
                if (rx_valid_reg) begin
                    we_next    = rx_shift_reg[7];
                    addr_next  = {rx_shift_reg[4:0], 8'h00};
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_err_reg) begin
                    state_next = S_IDLE;
                end else if (rx_valid_reg) begin
                    addr_next[7:0] = rx_shift_reg;
                    wcnt_next      = 2'd0;
                    state_next     = we_reg ? S_WDATA : S_BUS_REQ;
                end
            end
            S_WDATA: begin
                if (rx_err_reg) begin
                    state_next = S_IDLE;
                end else if (rx_valid_reg) begin
                    wdata_next[8*wcnt_reg +: 8] = rx_shift_reg;
                    if (wcnt_reg == 2'd3) state_next = S_BUS_REQ;
                    else                  wcnt_next  = wcnt_reg + 2'd1;
                end
            end
            S_BUS_REQ: begin
                if (mem_gnt_i && !mem_rvalid_i) state_next = S_BUS_WAIT;
            end
            S_RESP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 4'd9) begin
                        tx_bit_next = 4'd0;
                        if (tx_idx_reg == last_reg) state_next  = S_IDLE;
                        else                        tx_idx_next = tx_idx_reg + 2'd1;
                    end else begin
                        tx_bit_next = tx_bit_reg + 4'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            default: ;
        endcase
        if (resp_take) begin
            state_next  = S_RESP;
            resp_next   = we_reg ? 32'h0000_00A5 : mem_rdata_i;
            last_next   = we_reg ? 2'd0 : 2'd3;
            tx_idx_next = 2'd0;
            tx_bit_next = 4'd0;
            tx_cnt_next = '0;
        end
    end

    // Serial output and bus-side outputs decoded from registered state.
    always_comb begin
        tx_byte  = resp_reg[8*tx_idx_reg +: 8];
        tx_frame = {1'b1, tx_byte, 1'b0};
        tx_o     = (state_reg == S_RESP) ? tx_frame[tx_bit_reg] : 1'b1;
    end

    assign mem_req_o   = (state_reg == S_BUS_REQ);
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != S_IDLE);
    // bytes that arrive while the bus or the response is in progress are dropped silently
    assign frame_err_o = rx_err_reg &&
                         ((state_reg == S_IDLE) || (state_reg == S_ADDR) || (state_reg == S_WDATA));

endmodule

// File: tb/tb_uart_2_mem_resp.sv
// Scoreboard bench for uart_2_mem_resp: stimulus pushes expected bus requests,
// TX bytes and framing-error pulses; independent monitors pop and compare.
module tb_uart_2_mem_resp;
    localparam int CPB = 16;

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_i;
    logic        tx_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic        mem_we_o;
    logic [12:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        frame_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_count = 0;
    int tx_count  = 0;
    int gnt_delay = 0;
    int rv_delay  = 0;
    logic [31:0] rdata_cfg = 32'h0;

    bus_t       bus_exp[$];
    logic [7:0] tx_exp[$];
    int         ferr_exp[$];

    uart_2_mem_resp #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .tx_o(tx_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        rx_i = stopb;
        repeat (CPB) @(negedge clk_i);
        rx_i = 1'b1;
        if (!stopb) repeat (CPB) @(negedge clk_i);
    endtask

    task automatic push_tx(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) tx_exp.push_back(w[8*i +: 8]);
    endtask

    task automatic push_bus(input logic we, input logic [12:0] addr, input logic [31:0] wd);
        bus_t r;
        r.we = we; r.addr = addr; r.wdata = wd;
        bus_exp.push_back(r);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy_o !== 1'b0 || tx_exp.size() != 0 || bus_exp.size() != 0) && n < 6000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 6000) flag_fail({name, " timeout waiting for completion"});
        else $display("%s complete after %0d cycles", name, n);
    endtask

    // Bus responder: grants after gnt_delay, answers with rvalid after rv_delay.
    initial begin : responder
        bus_t        er;
        logic [12:0] a0;
        logic        w0;
        logic [31:0] d0;
        logic        unstable;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && mem_req_o === 1'b1) begin
                a0 = mem_addr_o; w0 = mem_we_o; d0 = mem_wdata_o; unstable = 1'b0;
                for (int i = 0; i < gnt_delay; i++) begin
                    @(negedge clk_i);
                    if (mem_req_o !== 1'b1 || mem_addr_o !== a0 || mem_we_o !== w0 || mem_wdata_o !== d0)
                        unstable = 1'b1;
                end
                check("req_stable", {31'd0, unstable}, 32'd0);
                if (bus_exp.size() == 0) begin
                    flag_fail("unexpected bus request");
                end else begin
                    er = bus_exp.pop_front();
                    check("req_addr", {19'd0, mem_addr_o}, {19'd0, er.addr});
                    check("req_we", {31'd0, mem_we_o}, {31'd0, er.we});
                    if (er.we) check("req_wdata", mem_wdata_o, er.wdata);
                end
                $display("bus request addr=%h we=%b wdata=%h after %0d stall cycles",
                         mem_addr_o, mem_we_o, mem_wdata_o, gnt_delay);
                mem_gnt_i    = 1'b1;
                mem_rvalid_i = (rv_delay == 0);
                mem_rdata_i  = rdata_cfg;
                @(negedge clk_i);
                mem_gnt_i    = 1'b0;
                mem_rvalid_i = 1'b0;
                gnt_count++;
                check("req_drop_after_gnt", {31'd0, mem_req_o}, 32'd0);
                if (rv_delay > 0) begin
                    repeat (rv_delay - 1) @(negedge clk_i);
                    mem_rvalid_i = 1'b1;
                    @(negedge clk_i);
                    mem_rvalid_i = 1'b0;
                end
                check("tx_start_after_resp", {31'd0, tx_o}, 32'd0);
            end
        end
    end

    // TX monitor: decodes serial bytes at bit centres and scores them.
    initial begin : tx_monitor
        logic [7:0] got;
        logic [7:0] ev;
        logic       stopb;
        logic       aborted;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && tx_o === 1'b0) begin
                aborted = 1'b0;
                for (int k = 0; k < CPB / 2; k++) begin
                    @(negedge clk_i);
                    if (rst_ni !== 1'b1) aborted = 1'b1;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < CPB; k++) begin
                        @(negedge clk_i);
                        if (rst_ni !== 1'b1) aborted = 1'b1;
                    end
                    got[i] = tx_o;
                end
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk_i);
                    if (rst_ni !== 1'b1) aborted = 1'b1;
                end
                stopb = tx_o;
                if (!aborted) begin
                    tx_count++;
                    if (tx_exp.size() == 0) begin
                        flag_fail("unexpected tx byte");
                    end else begin
                        ev = tx_exp.pop_front();
                        check("tx_byte", {24'd0, got}, {24'd0, ev});
                        check("tx_stop", {31'd0, stopb}, 32'd1);
                        $display("tx byte %h (expected %h)", got, ev);
                    end
                end
            end
        end
    end

    // Framing-error monitor.
    initial begin : ferr_monitor
        forever begin
            @(negedge clk_i);
            if (frame_err_o === 1'b1) begin
                if (ferr_exp.size() == 0) begin
                    flag_fail("unexpected frame_err_o pulse");
                end else begin
                    void'(ferr_exp.pop_front());
                    check("frame_err_busy", {31'd0, busy_o}, 32'd0);
                    $display("frame error pulse observed");
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int n;
        logic bad;
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", {19'd0, mem_addr_o}, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        $display("reset state checked");
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);

        // read 0x0123, grant+rvalid 3 cycles after the request
        gnt_delay = 3; rv_delay = 0; rdata_cfg = 32'hDEADBEEF;
        push_bus(1'b0, 13'h0123, 32'h0);
        push_tx(32'hDEADBEEF, 4);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        wait_done("read 0x0123");

        // write 0x1FFF with immediate grant
        gnt_delay = 0; rv_delay = 0; rdata_cfg = 32'h0;
        push_bus(1'b1, 13'h1FFF, 32'h12345678);
        push_tx(32'h000000A5, 1);
        send_byte(8'h9F, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_done("write 0x1FFF");

        // stalled grant; byte0 bits [6:5] set and ignored
        gnt_delay = 50; rv_delay = 0; rdata_cfg = 32'h01020304;
        push_bus(1'b0, 13'h0ABC, 32'h0);
        push_tx(32'h01020304, 4);
        send_byte(8'h6A, 1'b1);
        send_byte(8'hBC, 1'b1);
        wait_done("stalled read 0x0ABC");

        // framing error then a normal read
        ferr_exp.push_back(1);
        send_byte(8'h01, 1'b0);
        repeat (20) @(negedge clk_i);
        check("ferr_busy_after", {31'd0, busy_o}, 32'd0);
        check("ferr_pulses_seen", ferr_exp.size(), 32'd0);
        gnt_delay = 1; rv_delay = 0; rdata_cfg = 32'h80000001;
        push_bus(1'b0, 13'h0000, 32'h0);
        push_tx(32'h80000001, 4);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("read after frame error");

        // 2-cycle glitch on rx
        rx_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (60) @(negedge clk_i);
        check("glitch_busy", {31'd0, busy_o}, 32'd0);

        // bytes arriving during BUS_WAIT are dropped (one with a bad stop bit)
        gnt_delay = 2; rv_delay = 450; rdata_cfg = 32'hCAFEF00D;
        push_bus(1'b0, 13'h1042, 32'h0);
        push_tx(32'hCAFEF00D, 4);
        base = gnt_count;
        send_byte(8'h10, 1'b1);
        send_byte(8'h42, 1'b1);
        n = 0;
        while (gnt_count == base && n < 2000) begin @(negedge clk_i); n++; end
        if (n >= 2000) flag_fail("drop test timeout waiting for grant");
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b0);
        check("drop_busy_wait", {31'd0, busy_o}, 32'd1);
        wait_done("read 0x1042 with dropped bytes");

        // reset during the second response byte
        gnt_delay = 3; rv_delay = 0; rdata_cfg = 32'h11223344;
        push_bus(1'b0, 13'h0234, 32'h0);
        push_tx(32'h11223344, 2);
        base = tx_count;
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        n = 0;
        while (tx_count == base && n < 3000) begin @(negedge clk_i); n++; end
        if (n >= 3000) flag_fail("reset test timeout waiting for first byte");
        repeat (3 * CPB) @(negedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check("midtx_rst_tx", {31'd0, tx_o}, 32'd1);
        check("midtx_rst_busy", {31'd0, busy_o}, 32'd0);
        check("midtx_rst_req", {31'd0, mem_req_o}, 32'd0);
        tx_exp.delete();
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 1'b0;
        repeat (400) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) bad = 1'b1;
        end
        check("idle_after_reset", {31'd0, bad}, 32'd0);
        $display("reset during response checked");

        // fresh frame after reset
        gnt_delay = 3; rv_delay = 0; rdata_cfg = 32'h76543210;
        push_bus(1'b0, 13'h0123, 32'h0);
        push_tx(32'h76543210, 4);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        wait_done("read after reset");

        repeat (100) @(negedge clk_i);
        check("bus_queue_empty", bus_exp.size(), 32'd0);
        check("tx_queue_empty", tx_exp.size(), 32'd0);
        check("ferr_queue_empty", ferr_exp.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
